// File: rtl/mem_port_responder.sv
// mem_port_responder
//   Shares one single-port synchronous block RAM between CPU memory requests (fetch, load,
//   store) and display-scanner reads. Arbitrates, sequences one RAM access at a time and
//   returns read data with a one-cycle acknowledge.
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request (held until cpu_ack); we=1 is a store
//   cpu_ack, cpu_rdata    one-cycle completion pulse; load data held until the next CPU read
//   vid_req/addr          display read request (held until vid_ack)
//   vid_ack, vid_rdata    one-cycle completion pulse; data held until the next display read
//   ram_addr/we/wdata     registered RAM command
//   ram_rdata             RAM read data, valid RAM_LATENCY cycles after ram_addr
//   busy                  high whenever a transaction is in flight
module mem_port_responder #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAM_LATENCY = 1   // 1..4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  // WAIT counts down from RAM_LATENCY-1 to 0; data is captured on the zero cycle.
  localparam logic [1:0] WaitLoad = 2'(RAM_LATENCY - 1);

  state_e              state_q, state_d;
  logic                own_cpu_q, own_cpu_d;    // owner of the in-flight transaction
  logic                store_q, store_d;        // in-flight transaction is a CPU store
  logic                last_cpu_q, last_cpu_d;  // last grant went to the CPU
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_ack_q, vid_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
  logic                grant_cpu, grant_vid;

  // On a conflict the requester that did not win last time is served.
  assign grant_cpu = cpu_req && (!vid_req || !last_cpu_q);
  assign grant_vid = vid_req && (!cpu_req || last_cpu_q);

  always_comb begin
    state_d     = state_q;
    own_cpu_d   = own_cpu_q;
    store_d     = store_q;
    last_cpu_d  = last_cpu_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_cpu) begin
          own_cpu_d   = 1'b1;
          store_d     = cpu_we;
          last_cpu_d  = 1'b1;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          ram_we_d    = cpu_we;  // becomes visible during ACCESS
          state_d     = StAccess;
        end else if (grant_vid) begin
          own_cpu_d  = 1'b0;
          store_d    = 1'b0;
          last_cpu_d = 1'b0;
          ram_addr_d = vid_addr;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (store_q) begin
          cpu_ack_d = 1'b1;  // only the CPU can store
          state_d   = StResp;
        end else begin
          cnt_d   = WaitLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          if (own_cpu_q) begin
            cpu_rdata_d = ram_rdata;
            cpu_ack_d   = 1'b1;
          end else begin
            vid_rdata_d = ram_rdata;
            vid_ack_d   = 1'b1;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      own_cpu_q   <= 1'b0;
      store_q     <= 1'b0;
      last_cpu_q  <= 1'b0;
      cnt_q       <= 2'd0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_cpu_q   <= own_cpu_d;
      store_q     <= store_d;
      last_cpu_q  <= last_cpu_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: instance A with RAM_LATENCY=1, instance B with RAM_LATENCY=3,
// each with its own RAM model. Expected acks are queued when a request is driven and popped by
// a per-instance monitor when an ack appears.
module tb_mem_port_responder;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_cpu;
    bit          is_read;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // Instance A signals
  logic        cpu_req_a, cpu_we_a, cpu_ack_a, vid_req_a, vid_ack_a, ram_we_a, busy_a;
  logic [15:0] cpu_addr_a, cpu_wdata_a, cpu_rdata_a, vid_addr_a, vid_rdata_a;
  logic [15:0] ram_addr_a, ram_wdata_a, ram_rdata_a;
  // Instance B signals
  logic        cpu_req_b, cpu_we_b, cpu_ack_b, vid_req_b, vid_ack_b, ram_we_b, busy_b;
  logic [15:0] cpu_addr_b, cpu_wdata_b, cpu_rdata_b, vid_addr_b, vid_rdata_b;
  logic [15:0] ram_addr_b, ram_wdata_b, ram_rdata_b;

  mem_port_responder #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(1)) u_dut_a (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
    .cpu_ack(cpu_ack_a), .cpu_rdata(cpu_rdata_a),
    .vid_req(vid_req_a), .vid_addr(vid_addr_a), .vid_ack(vid_ack_a), .vid_rdata(vid_rdata_a),
    .ram_addr(ram_addr_a), .ram_we(ram_we_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a), .busy(busy_a)
  );

  mem_port_responder #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(3)) u_dut_b (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_ack(cpu_ack_b), .cpu_rdata(cpu_rdata_b),
    .vid_req(vid_req_b), .vid_addr(vid_addr_b), .vid_ack(vid_ack_b), .vid_rdata(vid_rdata_b),
    .ram_addr(ram_addr_b), .ram_we(ram_we_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b), .busy(busy_b)
  );

  // RAM models with a side port for preloading contents.
  logic        pre_we_a, pre_we_b;
  logic [15:0] pre_addr, pre_data;
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pa0;
  logic [15:0] pb0, pb1, pb2;

  always @(posedge clock) begin
    if (pre_we_a) mem_a[pre_addr] <= pre_data;
    else if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
    pa0 <= ram_addr_a;
  end
  assign ram_rdata_a = mem_a[pa0];

  always @(posedge clock) begin
    if (pre_we_b) mem_b[pre_addr] <= pre_data;
    else if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    pb0 <= ram_addr_b;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign ram_rdata_b = mem_b[pb2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int we_cnt_a = 0;

  always @(negedge clock) begin
    exp_t e;
    if (cpu_ack_a || vid_ack_a) begin
      check("acks_exclusive_a", 32'(cpu_ack_a & vid_ack_a), 32'd0);
      if (sb_a.size() == 0) begin
        check("unexpected_ack_a", 32'({cpu_ack_a, vid_ack_a}), 32'd0);
      end else begin
        e = sb_a.pop_front();
        check("ack_owner_a", 32'(cpu_ack_a), 32'(e.is_cpu));
        check("ack_cycle_a", 32'(cyc), 32'(e.cyc));
        if (e.is_read)
          check("rdata_a", 32'(e.is_cpu ? cpu_rdata_a : vid_rdata_a), 32'(e.data));
      end
    end
    if (ram_we_a) we_cnt_a++;
  end

  always @(negedge clock) begin
    exp_t e;
    if (cpu_ack_b || vid_ack_b) begin
      if (sb_b.size() == 0) begin
        check("unexpected_ack_b", 32'({cpu_ack_b, vid_ack_b}), 32'd0);
      end else begin
        e = sb_b.pop_front();
        check("ack_owner_b", 32'(cpu_ack_b), 32'(e.is_cpu));
        check("ack_cycle_b", 32'(cyc), 32'(e.cyc));
        if (e.is_read)
          check("rdata_b", 32'(e.is_cpu ? cpu_rdata_b : vid_rdata_b), 32'(e.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic preload(input bit to_b, input logic [15:0] addr, input logic [15:0] data);
    pre_addr = addr;
    pre_data = data;
    if (to_b) pre_we_b = 1'b1;
    else pre_we_a = 1'b1;
    step(1);
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  task automatic push_a(input bit is_cpu, input bit is_read, input logic [15:0] data,
                        input int ack_cyc);
    exp_t e;
    e.is_cpu = is_cpu; e.is_read = is_read; e.data = data; e.cyc = ack_cyc;
    sb_a.push_back(e);
  endtask

  task automatic wait_sb_a(input int budget);
    int n = 0;
    while (sb_a.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("timeout_a", 32'(sb_a.size()), 32'd0);
  endtask

  task automatic wait_sb_b(input int budget);
    int n = 0;
    while (sb_b.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("timeout_b", 32'(sb_b.size()), 32'd0);
  endtask

  initial begin
    int k;
    int we_base;
    exp_t e;
    reset = 1'b1;
    cpu_req_a = 0; cpu_we_a = 0; cpu_addr_a = '0; cpu_wdata_a = '0;
    vid_req_a = 0; vid_addr_a = '0;
    cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = '0; cpu_wdata_b = '0;
    vid_req_b = 0; vid_addr_b = '0;
    pre_we_a = 0; pre_we_b = 0; pre_addr = '0; pre_data = '0;
    step(2);
    preload(1'b0, 16'h0010, 16'hBEEF);
    preload(1'b0, 16'h0040, 16'h5555);
    preload(1'b0, 16'h0001, 16'h1111);
    preload(1'b0, 16'h0002, 16'h2222);
    preload(1'b1, 16'h0100, 16'hCAFE);
    preload(1'b1, 16'h0200, 16'hDEAD);
    reset = 1'b0;
    step(1);

    // Reset state
    check("rst_cpu_ack",   32'(cpu_ack_a),   32'd0);
    check("rst_vid_ack",   32'(vid_ack_a),   32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata_a), 32'd0);
    check("rst_vid_rdata", 32'(vid_rdata_a), 32'd0);
    check("rst_ram_addr",  32'(ram_addr_a),  32'd0);
    check("rst_ram_we",    32'(ram_we_a),    32'd0);
    check("rst_ram_wdata", 32'(ram_wdata_a), 32'd0);
    check("rst_busy",      32'(busy_a),      32'd0);
    check("rst_busy_b",    32'(busy_b),      32'd0);

    // 1: CPU read 0x10, LAT=1, ack 3 cycles after the request cycle
    k = cyc;
    cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 16'h0010;
    push_a(1'b1, 1'b1, 16'hBEEF, k + 3);
    wait_sb_a(20);
    cpu_req_a = 0;
    step(2);

    // 2: CPU store, then read back
    k = cyc;
    cpu_req_a = 1; cpu_we_a = 1; cpu_addr_a = 16'h0020; cpu_wdata_a = 16'h1234;
    push_a(1'b1, 1'b0, 16'h0000, k + 2);
    step(1);
    check("store_ram_we",    32'(ram_we_a),    32'd1);
    check("store_ram_addr",  32'(ram_addr_a),  32'h20);
    check("store_ram_wdata", 32'(ram_wdata_a), 32'h1234);
    check("store_busy",      32'(busy_a),      32'd1);
    wait_sb_a(20);
    k = cyc;
    cpu_we_a = 0; cpu_wdata_a = '0;
    push_a(1'b1, 1'b1, 16'h1234, k + 3);
    wait_sb_a(20);
    cpu_req_a = 0;
    step(2);

    // 3: both requesters held from reset, CPU stores, display reads
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    we_base = we_cnt_a;
    k = cyc;
    cpu_req_a = 1; cpu_we_a = 1; cpu_addr_a = 16'h0030; cpu_wdata_a = 16'hAAAA;
    vid_req_a = 1; vid_addr_a = 16'h0040;
    push_a(1'b1, 1'b0, 16'h0000, k + 2);
    push_a(1'b0, 1'b1, 16'h5555, k + 6);
    push_a(1'b1, 1'b0, 16'h0000, k + 9);
    push_a(1'b0, 1'b1, 16'h5555, k + 13);
    wait_sb_a(40);
    cpu_req_a = 0; vid_req_a = 0; cpu_we_a = 0;
    step(2);
    check("we_pulses_cpu_only", 32'(we_cnt_a - we_base), 32'd2);

    // 4: LAT=3 display read; address change after grant is ignored
    k = cyc;
    vid_req_b = 1; vid_addr_b = 16'h0100;
    e.is_cpu = 1'b0; e.is_read = 1'b1; e.data = 16'hCAFE; e.cyc = k + 5;
    sb_b.push_back(e);
    step(1);
    vid_addr_b = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      check("ram_addr_hold_b", 32'(ram_addr_b), 32'h100);
      step(1);
    end
    wait_sb_b(20);
    vid_req_b = 0;
    step(2);

    // 5: reset during WAIT of a CPU read aborts without an ack
    cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 16'h0010;
    step(2);
    check("abort_in_wait_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    step(1);
    check("abort_busy",      32'(busy_a),      32'd0);
    check("abort_ram_we",    32'(ram_we_a),    32'd0);
    check("abort_cpu_ack",   32'(cpu_ack_a),   32'd0);
    check("abort_cpu_rdata", 32'(cpu_rdata_a), 32'd0);
    reset = 1'b0; cpu_req_a = 0;
    step(3);
    k = cyc;
    cpu_req_a = 1; cpu_addr_a = 16'h0020;
    push_a(1'b1, 1'b1, 16'h1234, k + 3);
    wait_sb_a(20);
    cpu_req_a = 0;
    step(2);

    // 6: back-to-back CPU reads, req held across the ack
    k = cyc;
    cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 16'h0001;
    push_a(1'b1, 1'b1, 16'h1111, k + 3);
    wait_sb_a(20);
    cpu_addr_a = 16'h0002;
    push_a(1'b1, 1'b1, 16'h2222, k + 7);
    for (int i = 0; i < 3; i++) begin
      check("rdata_hold", 32'(cpu_rdata_a), 32'h1111);
      step(1);
    end
    wait_sb_a(20);
    cpu_req_a = 0;
    step(3);
    check("final_busy", 32'(busy_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
